// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWE,
    input  logic             LoWE,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int                  c_countW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_countW-1:0] c_lastCount = c_countW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [c_countW-1:0]   r_count;
    logic                  r_isDiv;
    logic                  r_negQ;
    logic                  r_negR;
    logic                  r_divZero;
    logic [WIDTH-1:0]      r_aRaw;
    logic [WIDTH-1:0]      r_operand;
    logic [2*WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic                  r_done;

    logic                  w_signed;
    logic [WIDTH-1:0]      w_absA;
    logic [WIDTH-1:0]      w_absB;
    logic [WIDTH:0]        w_mulSum;
    logic [2*WIDTH-1:0]    w_mulAcc;
    logic [WIDTH:0]        w_remShift;
    logic [WIDTH-1:0]      w_divDiff;
    logic                  w_divGe;
    logic [2*WIDTH-1:0]    w_divAcc;
    logic [2*WIDTH-1:0]    w_mulRes;
    logic [WIDTH-1:0]      w_quot;
    logic [WIDTH-1:0]      w_rem;
    logic [WIDTH-1:0]      w_fixHi;
    logic [WIDTH-1:0]      w_fixLo;

    assign Busy = (r_state != IDLE);
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Op[0] clear selects the signed variants.
    assign w_signed = ~Op[0];
    assign w_absA   = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_absB   = (w_signed && B[WIDTH-1]) ? -B : B;

    // Multiply step: add multiplicand into the upper half, shift right with carry.
    assign w_mulSum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
    assign w_mulAcc = {w_mulSum, r_acc[WIDTH-1:1]};

    // Restoring divide step; the shifted remainder needs one extra bit so
    // divisors above 2^(WIDTH-1) compare correctly.
    assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_divGe    = (w_remShift >= {1'b0, r_operand});
    assign w_divDiff  = w_remShift[WIDTH-1:0] - r_operand;
    assign w_divAcc   = {(w_divGe ? w_divDiff : w_remShift[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_divGe};

    assign w_mulRes = r_negQ ? -r_acc : r_acc;
    assign w_quot   = r_acc[WIDTH-1:0];
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fixHi = w_mulRes[2*WIDTH-1:WIDTH];
        w_fixLo = w_mulRes[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_fixHi = r_aRaw;
                w_fixLo = {WIDTH{1'b1}};
            end else begin
                w_fixHi = r_negR ? -w_rem  : w_rem;
                w_fixLo = r_negQ ? -w_quot : w_quot;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (Start) w_nextState = CALC;
            CALC:    if (r_count == c_lastCount) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_aRaw    <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_isDiv   <= Op[1];
                        r_negQ    <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_negR    <= w_signed & A[WIDTH-1];
                        r_divZero <= Op[1] && (B == '0);
                        r_aRaw    <= A;
                        r_count   <= '0;
                        if (Op[1]) begin
                            r_operand <= w_absB;
                            r_acc     <= {{WIDTH{1'b0}}, w_absA};
                        end else begin
                            r_operand <= w_absA;
                            r_acc     <= {{WIDTH{1'b0}}, w_absB};
                        end
                    end else begin
                        if (HiWE) r_hi <= WriteData;
                        if (LoWE) r_lo <= WriteData;
                    end
                end
                CALC: begin
                    r_acc   <= r_isDiv ? w_divAcc : w_mulAcc;
                    r_count <= r_count + c_countW'(1);
                end
                FIX: begin
                    r_hi   <= w_fixHi;
                    r_lo   <= w_fixLo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWE;
    logic        LoWE;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelHi  = '0;
    logic [31:0] modelLo  = '0;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;

    always #5 CLK = ~CLK;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .HiWE      (HiWE),
        .LoWE      (LoWE),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO)
    );

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one operation and follows it to completion; hazCycle >= 0 pulses
    // Start plus both write enables at that busy cycle.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi,
                         input logic [31:0] expLo, input int hazCycle);
        int n;
        Start = 1'b1; Op = op; A = a; B = b;
        step;
        Start = 1'b0; HiWE = 1'b0; LoWE = 1'b0;
        Op = ~op; A = $urandom; B = $urandom;
        check({tag, "_busy0"}, {63'd0, Busy}, 64'd1);
        check({tag, "_done0"}, {63'd0, Done}, 64'd0);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            if (n == 16) check({tag, "_hold"}, {HI, LO}, {modelHi, modelLo});
            if (n == hazCycle) begin
                Start = 1'b1; HiWE = 1'b1; LoWE = 1'b1; WriteData = 32'hDEAD_BEEF;
            end
            step;
            Start = 1'b0; HiWE = 1'b0; LoWE = 1'b0;
            n++;
        end
        check({tag, "_busyCycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'd0, Done}, 64'd1);
        check({tag, "_HI"}, {32'd0, HI}, {32'd0, expHi});
        check({tag, "_LO"}, {32'd0, LO}, {32'd0, expLo});
        modelHi = expHi;
        modelLo = expLo;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        HiWE = 1'b0; LoWE = 1'b0; WriteData = '0;
        repeat (3) step;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        Reset = 1'b0;
        step;
        check("idle_busy", {63'd0, Busy}, 64'd0);

        // Back-to-back calls start each op in the cycle its predecessor shows Done.
        runOp("mult_neg3x5",   c_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
        runOp("multu_max",     c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        runOp("mult_m1xm1",    c_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, -1);
        runOp("div_neg7by2",   c_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        runOp("div_7byneg2",   c_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, -1);
        runOp("divu_100by7",   c_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        -1);
        runOp("divu_by0",      c_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, -1);
        runOp("div_by0",       c_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
        runOp("div_overflow",  c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, -1);
        runOp("multu_hazard",  c_MULTU, 32'd6,         32'd7,        32'd0,         32'd42,         9);

        step;
        check("post_done_clear", {63'd0, Done}, 64'd0);
        HiWE = 1'b1; WriteData = 32'h0000_1234;
        step;
        HiWE = 1'b0;
        check("mthi_HI", {32'd0, HI}, 64'h1234);
        check("mthi_LO", {32'd0, LO}, 64'd42);
        check("mthi_done", {63'd0, Done}, 64'd0);
        HiWE = 1'b1; LoWE = 1'b1; WriteData = 32'h0000_55AA;
        step;
        HiWE = 1'b0; LoWE = 1'b0;
        check("mthilo_both", {HI, LO}, {32'h55AA, 32'h55AA});
        modelHi = 32'h55AA;
        modelLo = 32'h55AA;

        // Write enables alongside Start must be dropped; the hold check sees it.
        HiWE = 1'b1; LoWE = 1'b1; WriteData = 32'hBAD0_BAD0;
        runOp("mult_startwe",  c_MULT,  32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, -1);

        Start = 1'b1; Op = c_DIVU; A = 32'd100; B = 32'd7;
        step;
        Start = 1'b0;
        repeat (14) step;
        check("midop_busy", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        check("midrst_busy", {63'd0, Busy}, 64'd0);
        check("midrst_hilo", {HI, LO}, 64'd0);
        check("midrst_done", {63'd0, Done}, 64'd0);
        modelHi = '0;
        modelLo = '0;
        repeat (25) step;
        check("midrst_nodone", {62'd0, Busy, Done}, 64'd0);
        runOp("multu_after_rst", c_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1);
        step;
        check("final_done_clear", {63'd0, Done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit downstream of the register file's read ports.
- Consumes the rs/rt operand pair (ReadData1/ReadData2) and holds the 64-bit result in HI/LO registers.
- The datapath reads HI/LO back (MFHI/MFLO) and writes them directly (MTHI/MTLO).
- Radix-2 shift-add / restoring-divide engine; a single-cycle CPU stalls on Busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- CLK  input  1  clock; all state updates on posedge CLK.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin operation Op on A/B; sampled only when idle.
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  WIDTH  rs operand (ReadData1); dividend / multiplicand.
- B  input  WIDTH  rt operand (ReadData2); divisor / multiplier.
- HiWE  input  1  MTHI write enable.
- LoWE  input  1  MTLO write enable.
- WriteData  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  output  WIDTH  high product / remainder.
- LO  output  WIDTH  low product / quotient.

Behaviour:
- Reset: state IDLE, HI=0, LO=0, Busy=0, Done=0, internal counter and accumulators cleared. Reset has priority over all inputs, including mid-operation: the operation is abandoned and no result is written.
- States: IDLE, CALC, FIX. Busy = (state != IDLE), decoded from registered state.
- IDLE, Start=1 at edge k:
  - Latch Op and absolute values of A and B. Absolute values apply to signed ops only; unsigned ops latch raw values.
  - Latch sign flags: product/quotient sign = A[msb]^B[msb]; remainder sign = A[msb].
  - Clear counter; go to CALC.
- CALC, one iteration per edge, edges k+1 .. k+WIDTH; counter 0..WIDTH-1. At counter = WIDTH-1, go to FIX.
  - Multiply: conditional add of multiplicand into the upper half of a 2*WIDTH accumulator, then shift right.
  - Divide: restoring step on a 2*WIDTH remainder/quotient register, producing one quotient bit.
- FIX, edge k+WIDTH+1:
  - Apply sign correction: two's-complement negate the 64-bit product, or the quotient and the remainder independently.
  - Write HI/LO, set Done=1 for exactly one cycle, return to IDLE.
- Latency: Busy high for WIDTH+1 cycles (33); Done high in the cycle after edge k+33; HI/LO hold old values until then.
- Divide by zero (B==0, either signedness):
  - Full latency is still taken; Busy/Done timing is identical.
  - Result: LO = all ones, HI = A as presented (unmodified).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Falls out naturally from magnitude arithmetic.
- Start while Busy: ignored, no queuing; the in-flight operation is unaffected.
- HiWE/LoWE:
  - Honoured only in IDLE with Start=0; HI/LO update at that edge with WriteData; Done is not asserted.
  - Both HiWE and LoWE high: both registers are written.
  - Ignored while Busy.
  - In IDLE with Start=1 in the same cycle: Start wins and the write is dropped.
- Done and Start may coincide: in the cycle Done=1, state is IDLE, so a new Start is accepted.
- No combinational path from any input to Busy, Done, HI or LO.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5 -> Busy high 33 cycles; then Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Same operands with MULT -> HI=0, LO=1.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=100, B=7 -> LO=14, HI=2.
- DIVU, A=100, B=0 -> after 33 busy cycles LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazards:
  - Start MULTU 6*7, pulse Start again with HiWE at cycle 10 -> second Start and write ignored; result HI=0, LO=42 at cycle 33.
  - Then in IDLE, HiWE=1, WriteData=0x1234 -> HI=0x1234, Done stays 0.
- Reset mid-op: start DIVU 100/7, assert Reset at cycle 15 -> next edge Busy=0, HI=LO=0, no Done pulse. Next Start completes normally.
